// File: rtl/rpn_operand_stack.sv
// Operand stack for the 8-bit RPN ALU: shift-register stack whose top two entries
// feed the ALU, with ALU results written back on exec commands.
module rpn_operand_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  input  logic               exec_bin,
  input  logic               exec_un,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0]   operand_a,
  output logic [WIDTH-1:0]   operand_b,
  output logic [4:0]         depth,
  output logic               empty,
  output logic               full,
  output logic               ack,
  output logic               err,
  output logic               err_sticky,
  output logic               ovf
);

  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic             result_hi;

  assign result_hi = |alu_result[2*WIDTH-1:WIDTH];

  // Entry 0 is the top; vacated slots always load zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      depth      <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        depth      <= '0;
        ovf        <= 1'b0;
        err_sticky <= 1'b0;
        ack        <= 1'b1;
      end else if (exec_bin) begin
        if (depth >= 5'd2) begin
          entries[0] <= alu_result[WIDTH-1:0];
          for (int i = 1; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
          entries[DEPTH-1] <= '0;
          depth <= depth - 5'd1;
          ovf   <= result_hi;
          ack   <= 1'b1;
        end else begin
          err        <= 1'b1;
          err_sticky <= 1'b1;
        end
      end else if (exec_un) begin
        if (depth != 5'd0) begin
          entries[0] <= alu_result[WIDTH-1:0];
          ovf        <= result_hi;
          ack        <= 1'b1;
        end else begin
          err        <= 1'b1;
          err_sticky <= 1'b1;
        end
      end else if (push) begin
        if (depth != DEPTH_MAX) begin
          entries[0] <= push_data;
          for (int i = 1; i < DEPTH; i++) entries[i] <= entries[i-1];
          depth <= depth + 5'd1;
          ack   <= 1'b1;
        end else begin
          err        <= 1'b1;
          err_sticky <= 1'b1;
        end
      end else if (pop) begin
        if (depth != 5'd0) begin
          for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
          entries[DEPTH-1] <= '0;
          depth <= depth - 5'd1;
          ack   <= 1'b1;
        end else begin
          err        <= 1'b1;
          err_sticky <= 1'b1;
        end
      end
    end
  end

  assign operand_b = (depth != 5'd0) ? entries[0] : '0;
  assign operand_a = (depth >= 5'd2) ? entries[1] : '0;
  assign empty     = (depth == 5'd0);
  assign full      = (depth == DEPTH_MAX);

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Directed self-checking bench for rpn_operand_stack with hand-computed expectations
// (DEPTH=4, WIDTH=8).
module tb_rpn_operand_stack;

  logic        clk = 1'b0;
  logic        reset, clear, push, pop, exec_bin, exec_un;
  logic [7:0]  push_data;
  logic [15:0] alu_result;
  logic [7:0]  operand_a, operand_b;
  logic [4:0]  depth;
  logic        empty, full, ack, err, err_sticky, ovf;

  int checks = 0;
  int errors = 0;

  rpn_operand_stack #(.DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .push_data(push_data),
    .pop(pop), .exec_bin(exec_bin), .exec_un(exec_un), .alu_result(alu_result),
    .operand_a(operand_a), .operand_b(operand_b), .depth(depth), .empty(empty),
    .full(full), .ack(ack), .err(err), .err_sticky(err_sticky), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's command, let the edge take it, then sample 1ns later.
  task automatic applyStimulus(input logic c_reset, input logic c_clear,
                               input logic c_push, input logic [7:0] data,
                               input logic c_pop, input logic c_bin,
                               input logic c_un, input logic [15:0] res);
    reset = c_reset; clear = c_clear; push = c_push; push_data = data;
    pop = c_pop; exec_bin = c_bin; exec_un = c_un; alu_result = res;
    @(posedge clk);
    #1;
    reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    exec_bin = 1'b0; exec_un = 1'b0; push_data = 8'h00; alu_result = 16'h0000;
  endtask

  task automatic doPush(input logic [7:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, data, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_depth"}, 16'(depth), 16'd0);
    checkOutput({tag, "_empty"}, 16'(empty), 16'd1);
    checkOutput({tag, "_full"}, 16'(full), 16'd0);
    checkOutput({tag, "_opa"}, 16'(operand_a), 16'h00);
    checkOutput({tag, "_opb"}, 16'(operand_b), 16'h00);
    checkOutput({tag, "_ack"}, 16'(ack), 16'd0);
    checkOutput({tag, "_err"}, 16'(err), 16'd0);
    checkOutput({tag, "_errs"}, 16'(err_sticky), 16'd0);
    checkOutput({tag, "_ovf"}, 16'(ovf), 16'd0);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0;
    exec_bin = 1'b0; exec_un = 1'b0; push_data = 8'h00; alu_result = 16'h0000;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkResetState("rst");

    // Push 05, 03.
    doPush(8'h05);
    checkOutput("p1_ack", 16'(ack), 16'd1);
    checkOutput("p1_depth", 16'(depth), 16'd1);
    doPush(8'h03);
    checkOutput("p2_ack", 16'(ack), 16'd1);
    checkOutput("p2_depth", 16'(depth), 16'd2);
    checkOutput("p2_opa", 16'(operand_a), 16'h05);
    checkOutput("p2_opb", 16'(operand_b), 16'h03);
    checkOutput("p2_errs", 16'(err_sticky), 16'd0);

    // Add: 5+3.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0008);
    checkOutput("add_depth", 16'(depth), 16'd1);
    checkOutput("add_opb", 16'(operand_b), 16'h08);
    checkOutput("add_opa", 16'(operand_a), 16'h00);
    checkOutput("add_ovf", 16'(ovf), 16'd0);
    checkOutput("add_ack", 16'(ack), 16'd1);

    // Multiply 0x20*0x10 overflows into the high byte; stack becomes 00,08.
    doPush(8'h20);
    doPush(8'h10);
    checkOutput("mulpre_depth", 16'(depth), 16'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0200);
    checkOutput("mul_opb", 16'(operand_b), 16'h00);
    checkOutput("mul_opa", 16'(operand_a), 16'h08);
    checkOutput("mul_ovf", 16'(ovf), 16'd1);
    checkOutput("mul_depth", 16'(depth), 16'd2);
    doPush(8'h01);
    checkOutput("mulpush_ovf", 16'(ovf), 16'd1);
    checkOutput("mulpush_depth", 16'(depth), 16'd3);

    // Clear then fill to DEPTH.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("clr1_ack", 16'(ack), 16'd1);
    checkOutput("clr1_depth", 16'(depth), 16'd0);
    checkOutput("clr1_ovf", 16'(ovf), 16'd0);
    for (int i = 1; i <= 4; i++) begin
      doPush(8'(i));
      checkOutput("fill_full", 16'(full), (i == 4) ? 16'd1 : 16'd0);
    end
    doPush(8'h55);
    checkOutput("ovp_err", 16'(err), 16'd1);
    checkOutput("ovp_ack", 16'(ack), 16'd0);
    checkOutput("ovp_errs", 16'(err_sticky), 16'd1);
    checkOutput("ovp_full", 16'(full), 16'd1);
    checkOutput("ovp_opb", 16'(operand_b), 16'h04);
    checkOutput("ovp_opa", 16'(operand_a), 16'h03);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h00FB);
    checkOutput("not_opb", 16'(operand_b), 16'hFB);
    checkOutput("not_depth", 16'(depth), 16'd4);
    checkOutput("not_ack", 16'(ack), 16'd1);
    checkOutput("not_err", 16'(err), 16'd0);
    checkOutput("not_errs", 16'(err_sticky), 16'd1);
    // exec_bin at full: FB,03,02,01 -> 05,02,01.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0105);
    checkOutput("fbin_full", 16'(full), 16'd0);
    checkOutput("fbin_depth", 16'(depth), 16'd3);
    checkOutput("fbin_opb", 16'(operand_b), 16'h05);
    checkOutput("fbin_opa", 16'(operand_a), 16'h02);
    checkOutput("fbin_ovf", 16'(ovf), 16'd1);

    // Underflow cases from empty.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("upop_err", 16'(err), 16'd1);
    checkOutput("upop_depth", 16'(depth), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h00AA);
    checkOutput("uun_err", 16'(err), 16'd1);
    checkOutput("uun_depth", 16'(depth), 16'd0);
    doPush(8'h07);
    checkOutput("u7_ack", 16'(ack), 16'd1);
    checkOutput("u7_err", 16'(err), 16'd0);
    checkOutput("u7_opb", 16'(operand_b), 16'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0099);
    checkOutput("ubin_err", 16'(err), 16'd1);
    checkOutput("ubin_ack", 16'(ack), 16'd0);
    checkOutput("ubin_depth", 16'(depth), 16'd1);
    checkOutput("ubin_opb", 16'(operand_b), 16'h07);
    checkOutput("ubin_errs", 16'(err_sticky), 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("clr2_depth", 16'(depth), 16'd0);
    checkOutput("clr2_errs", 16'(err_sticky), 16'd0);
    checkOutput("clr2_ack", 16'(ack), 16'd1);

    // Pop at depth 1 sets empty.
    doPush(8'h09);
    checkOutput("p9_empty", 16'(empty), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("pop1_empty", 16'(empty), 16'd1);
    checkOutput("pop1_ack", 16'(ack), 16'd1);
    checkOutput("pop1_opb", 16'(operand_b), 16'h00);

    // Priority: push beats pop; exec_un beats push.
    doPush(8'h0A);
    doPush(8'h0B);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("pp_depth", 16'(depth), 16'd3);
    checkOutput("pp_opb", 16'(operand_b), 16'h0C);
    checkOutput("pp_opa", 16'(operand_a), 16'h0B);
    checkOutput("pp_ack", 16'(ack), 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 16'h00F3);
    checkOutput("up_depth", 16'(depth), 16'd3);
    checkOutput("up_opb", 16'(operand_b), 16'hF3);

    // Reset dominates exec_bin.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0123);
    checkResetState("rstbin");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
